inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, byte PC loaded at reset.
REQ-003 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have imem_addr  output  6  word address to instruction memory (= fetch_pc[7:2]).
REQ-006 SHALL have imem_data  input  32  instruction word, combinational from imem_addr in the same cycle.
REQ-007 SHALL have redirect_valid  input  1  branch/jump redirect strobe.
REQ-008 SHALL have redirect_pc  input  32  redirect target byte PC.
REQ-009 SHALL have out_valid  output  1  queue head valid to decode.
REQ-010 SHALL have out_ready  input  1  decode accepts head.
REQ-011 SHALL have out_inst  output  32  head instruction.
REQ-012 SHALL have out_pc  output  32  byte PC of head instruction.

Function
REQ-013 SHALL hold fetch_pc (32 b), circular buffer of DEPTH {pc,inst} entries, rd_ptr, wr_ptr, count (clog2(DEPTH)+1 b).
REQ-014 SHALL drive imem_addr = fetch_pc[7:2] continuously; addresses wrap modulo 64 words.
REQ-015 Push: when no redirect and (count < DEPTH or pop this cycle), SHALL write {fetch_pc, imem_data} at wr_ptr and set fetch_pc <= fetch_pc + 4 (32-bit wrap).
REQ-016 Pop: out_valid = (count != 0); pop occurs when out_valid && out_ready && !redirect_valid; rd_ptr advances.
REQ-017 Simultaneous push and pop when full SHALL be permitted; count unchanged.
REQ-018 Full (count == DEPTH) with no pop: no push, fetch_pc holds.
REQ-019 Redirect SHALL take priority over push and pop: next cycle count = 0, pointers = 0, fetch_pc = {redirect_pc[31:2], 2'b00}; head that cycle is not consumed.
REQ-020 Bits redirect_pc[1:0] SHALL be ignored.
REQ-021 out_inst/out_pc SHALL be the head entry; value don't-care when out_valid = 0 (with IFQ_BYPASS_EN not defined).
REQ-022 Latency: instruction at fetch_pc SHALL appear on out_valid one cycle after its push cycle (non-bypass).
REQ-023 Entries SHALL leave in fetch order; no duplication, no drop except on redirect flush.

Reset
REQ-024 On rst_n low, asynchronously: fetch_pc = RESET_PC (bits [1:0] cleared), count = 0, pointers = 0, out_valid = 0.
REQ-025 Reset mid-operation SHALL discard all entries; first push occurs on first rising edge after rst_n rises, first out_valid one cycle later.

Configuration
REQ-026 Macro IFQ_BYPASS_EN: when defined and count == 0 and !redirect_valid, SHALL present out_valid = 1, out_inst = imem_data, out_pc = fetch_pc combinationally; if out_ready, the word is consumed without a push and fetch_pc advances.
REQ-027 When IFQ_BYPASS_EN is undefined, behaviour SHALL be per REQ-016/REQ-022 only (minimum 1-cycle latency).

Verification
REQ-028 Reset release, imem word n = 32'h100+n, out_ready = 1 -> out_pc 0,4,8,... with out_inst 32'h100,32'h101,... one per cycle after first-valid cycle.
REQ-029 out_ready = 0 for 10 cycles -> exactly DEPTH=4 entries (pc 0..12), imem_addr holds at 4, then out_ready = 1 drains in order pc 0,4,8,12,16.
REQ-030 Redirect to 32'h0000_0023 while 3 entries queued -> next cycle out_valid = 0, imem_addr = 8; following cycle out_pc = 32'h20.
REQ-031 Redirect and out_ready asserted same cycle on full queue -> no entry consumed by decode, queue empty next cycle.
REQ-032 fetch_pc 32'hFFFF_FFFC pushed -> next fetch_pc 32'h0, imem_addr 0; imem_addr 63 followed by 0 at pc 32'h100.
REQ-033 rst_n asserted asynchronously mid-drain -> out_valid drops immediately; with IFQ_BYPASS_EN defined, out_valid = 1 and out_pc = RESET_PC in the first cycle after rst_n rises.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: fetches one word per cycle into a DEPTH-entry FIFO toward decode.
// Optional macro IFQ_BYPASS_EN lets an empty queue hand the fetched word straight to decode.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [5:0]  imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          bypass_take;
  logic          advance;
  logic          unused_redirect_bits;

  assign imem_addr            = fetch_pc[7:2];
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // A redirect overrides everything: no push, and the current head is not consumed.
  always_comb begin
    out_valid   = (count != '0);
    out_inst    = inst_mem[rd_ptr];
    out_pc      = pc_mem[rd_ptr];
    bypass_take = 1'b0;
    pop         = (count != '0) && out_ready && !redirect_valid;
`ifdef IFQ_BYPASS_EN
    if ((count == '0) && !redirect_valid && rst_n) begin
      out_valid   = 1'b1;
      out_inst    = imem_data;
      out_pc      = fetch_pc;
      bypass_take = out_ready;
    end
`endif
    push    = !redirect_valid && !bypass_take && ((count != FULL_CNT) || pop);
    advance = push || bypass_take;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (advance) fetch_pc <= fetch_pc + 32'd4;
      if (push)    wr_ptr   <= wr_ptr + PW'(1);
      if (pop)     rd_ptr   <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage needs no reset; count gates visibility of stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: queue-based reference model plus directed literal checks.
// Works with or without IFQ_BYPASS_EN defined.
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  int checks   = 0;
  int failures = 0;

  logic [63:0] m_q[$];
  logic [31:0] m_pc;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory: word n holds 32'h100 + n.
  assign imem_data = 32'h100 + {26'd0, imem_addr};

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h100 + {26'd0, pc[7:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: compare at negedge, then advance one clock of queue behaviour.
  always @(negedge clk) begin
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    int          sz;
    logic        pop;
    logic        push;
    if (!rst_n) begin
      m_q.delete();
      m_pc = {RESET_PC[31:2], 2'b00};
      check("reset_out_valid", out_valid, 0);
      check("reset_imem_addr", imem_addr, m_pc[7:2]);
    end else begin
      sz        = m_q.size();
      exp_valid = (sz != 0) || (BYP && !redirect_valid);
      exp_pc    = (sz != 0) ? m_q[0][63:32] : m_pc;
      exp_inst  = (sz != 0) ? m_q[0][31:0]  : inst_of(m_pc);
      check("model_out_valid", out_valid, exp_valid);
      check("model_imem_addr", imem_addr, m_pc[7:2]);
      if (exp_valid) begin
        check("model_out_pc", out_pc, exp_pc);
        check("model_out_inst", out_inst, exp_inst);
      end
      if (redirect_valid) begin
        m_q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else if (BYP && sz == 0) begin
        if (!out_ready) m_q.push_back({m_pc, inst_of(m_pc)});
        m_pc = m_pc + 32'd4;
      end else begin
        pop  = (sz > 0) && out_ready;
        push = (sz < DEPTH) || pop;
        if (pop) void'(m_q.pop_front());
        if (push) begin
          m_q.push_back({m_pc, inst_of(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc, input logic rdy);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    out_ready      = rdy;
    step();
    redirect_valid = 1'b0;
  endtask

  // Called at posedge+1 with rst_n low and out_ready high.
  task automatic release_reset;
    #1 rst_n = 1'b1;
    #1;
`ifdef IFQ_BYPASS_EN
    check("rel_bypass_valid", out_valid, 1);
    check("rel_bypass_pc", out_pc, RESET_PC);
`else
    check("rel_valid_low", out_valid, 0);
    @(negedge clk);
    check("rel_prefetch_valid", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stream_valid", out_valid, 1);
      check("stream_pc", out_pc, 32'(4 * k));
      check("stream_inst", out_inst, 32'h100 + 32'(k));
    end
`endif
    step();
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    repeat (2) step();
    release_reset();

    // Stall decode: queue fills to DEPTH and fetch holds, then drains in order.
    do_redirect(32'h0, 1'b0);
    repeat (10) step();
    @(negedge clk);
    check("full_valid", out_valid, 1);
    check("full_head_pc", out_pc, 32'h0);
    check("full_imem_addr", imem_addr, 6'd4);
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("drain_pc", out_pc, 32'(4 * k));
      step();
    end

    // Redirect with three entries queued; low address bits ignored.
    do_redirect(32'h0, 1'b0);
    repeat (3) step();
    do_redirect(32'h0000_0023, 1'b1);
    out_ready = 1'b0;
    @(negedge clk);
`ifndef IFQ_BYPASS_EN
    check("redir_valid_low", out_valid, 0);
`endif
    check("redir_imem_addr", imem_addr, 6'd8);
    step();
    @(negedge clk);
    check("redir_head_pc", out_pc, 32'h20);
    check("redir_head_inst", out_inst, 32'h108);
    step();

    // Redirect and out_ready together on a full queue.
    do_redirect(32'h40, 1'b0);
    repeat (6) step();
    do_redirect(32'h80, 1'b1);
    @(negedge clk);
`ifndef IFQ_BYPASS_EN
    check("redir_full_empty", out_valid, 0);
`endif
    check("redir_full_addr", imem_addr, 6'd32);
    step();
`ifndef IFQ_BYPASS_EN
    @(negedge clk);
    check("redir_full_head", out_pc, 32'h80);
    step();
`endif

    // 32-bit PC wrap and 64-word address wrap.
    do_redirect(32'hFFFF_FFF8, 1'b1);
    @(negedge clk);
    check("wrap_addr62", imem_addr, 6'd62);
    step();
    @(negedge clk);
    check("wrap_addr63", imem_addr, 6'd63);
`ifndef IFQ_BYPASS_EN
    check("wrap_pc_fff8", out_pc, 32'hFFFF_FFF8);
`endif
    step();
    @(negedge clk);
    check("wrap_addr0", imem_addr, 6'd0);
`ifndef IFQ_BYPASS_EN
    check("wrap_pc_fffc", out_pc, 32'hFFFF_FFFC);
    check("wrap_inst_13f", out_inst, 32'h13F);
`endif
    step();
    do_redirect(32'hFC, 1'b1);
    @(negedge clk);
    check("wrap_fc_addr63", imem_addr, 6'd63);
    step();
    @(negedge clk);
    check("wrap_100_addr0", imem_addr, 6'd0);
    step();

    // Asynchronous reset in the middle of a drain.
    out_ready = 1'b0;
    do_redirect(32'h0, 1'b0);
    repeat (5) step();
    out_ready = 1'b1;
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1 check("async_rst_valid", out_valid, 0);
    step();
    step();
    release_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if (i < 400) out_ready = ($urandom_range(0, 3) != 0);
      else         out_ready = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
